spi_frame_writer: RTL and testbench
===================================

Name: spi_frame_writer

Overview:
- Consumes the byte stream from the SPI slave stage (data/valid/sot/eot) and packs each group of 3 bytes into one 24-bit RGB pixel.
- Writes each pixel at a linear address into the back bank of a double-buffered framebuffer.
- Flips the display bank at end of transfer, so the display scanner always reads a complete frame.

Parameters:
- WIDTH, 32, pixels per row.
- HEIGHT, 16, rows per frame.
- ADDR_W, 9, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  8  byte from SPI slave.
- in_valid  in  1  one-cycle strobe; in_data valid this cycle.
- in_sot  in  1  high with in_valid on the first byte of a transfer.
- in_eot  in  1  level; high while slave select is deasserted.
- fb_waddr  out  ADDR_W  pixel write address, row-major, from 0.
- fb_wdata  out  24  {R,G,B}; R is the first byte received.
- fb_we  out  1  write strobe, one cycle per pixel.
- fb_wbank  out  1  bank being written; always ~disp_bank.
- disp_bank  out  1  bank the display reads.
- flip  out  1  one-cycle pulse when disp_bank toggles.
- ovf  out  1  sticky: more than WIDTH*HEIGHT pixels received this transfer.

Behaviour:
- Reset (rst=0, async): state IDLE, byte_idx=0, pix_cnt=0.
- Reset output values: fb_waddr=0, fb_wdata=0, fb_we=0, disp_bank=0, fb_wbank=1, flip=0, ovf=0.
- Reset mid-transfer discards the partial frame and performs no flip.
- States: IDLE, RECV, FLIP.

IDLE:
- in_valid&in_sot: go to RECV.
  - Consume the byte as byte 0 (R): byte_idx=1, pix_cnt=0, ovf cleared.
- in_valid without in_sot: ignored.

RECV:
- in_valid: latch the byte into slot byte_idx (0=R, 1=G, 2=B).
  - byte_idx counts 0→1→2→0.
  - On the B byte: fb_we=1 the next cycle, with fb_waddr=pix_cnt and fb_wdata={R,G,B}.
  - Write latency is 1 cycle from the B byte's in_valid.
  - pix_cnt increments after each write.
- pix_cnt == WIDTH*HEIGHT when a pixel completes: no write, ovf=1.
  - pix_cnt saturates at that value; no address wrap.
- in_valid&in_sot in RECV: restart as in IDLE. The partially written frame is not flipped.
- in_eot=1:
  - A partial pixel (byte_idx≠0) is discarded.
  - If pix_cnt>0, go to FLIP; else go to IDLE.
- in_eot has priority over in_valid in the same cycle; that byte is dropped.

FLIP:
- One cycle: disp_bank toggles, flip=1 for exactly this cycle, fb_wbank follows.
- Returns to IDLE.
- in_valid in FLIP is ignored.

Other rules:
- fb_we is only ever high in RECV-derived cycles.
- fb_we is never high in the same cycle as flip.
- ovf holds until the next accepted in_sot or reset.
- A frame shorter than WIDTH*HEIGHT still flips (unless the check below is enabled); unwritten addresses keep stale back-bank data.

Optional Feature:
- SPI_FRAME_WRITER_FRAME_CHECK_EN defined:
  - Flip only if pix_cnt == WIDTH*HEIGHT, byte_idx == 0 and ovf == 0 at eot.
  - Otherwise return to IDLE with no flip, and a sticky output bad_frame (1 bit, reset 0) sets.
  - bad_frame clears on the next successful flip.
- Not defined: no bad_frame port; flip rule as in Behaviour.

Test Plan:
- Full frame:
  - Stimulus: sot, then 1536 bytes (R=G=B=i[7:0] for pixel i), then eot.
  - Response: 512 fb_we pulses, addr 0..511, fb_wbank=1, wdata for pixel 5 = 0x050505; then flip pulse, disp_bank=1, fb_wbank=0.
- Partial pixel:
  - Stimulus: sot, bytes 0x11,0x22,0x33,0x44, eot.
  - Response: one write, addr 0, data 0x112233; byte 0x44 discarded; flip=1.
- Overflow:
  - Stimulus: 513 full pixels.
  - Response: 512 writes; ovf=1 after the 513th B byte, stays 1 until the next sot; ovf returns to 0 on the next sot.
- Empty transfer:
  - Stimulus: sot byte only (1 byte), then eot.
  - Response: no write, no flip, disp_bank unchanged.
- Async reset mid-transfer:
  - Stimulus: rst=0 between the G and B bytes of pixel 3.
  - Response: outputs at reset values immediately; no write, no flip; the next sot frame starts at addr 0.
- Frame check:
  - Stimulus: with SPI_FRAME_WRITER_FRAME_CHECK_EN, 10 pixels then eot.
  - Response: no flip, bad_frame=1; a following full frame flips and clears bad_frame.

Source files
------------

// File: rtl/spi_frame_writer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : spi_frame_writer_if
// Brief    : Byte-stream input and framebuffer write bus for spi_frame_writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface spi_frame_writer_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_sot;
  logic              in_eot;
  logic [ADDR_W-1:0] fb_waddr;
  logic [23:0]       fb_wdata;
  logic              fb_we;
  logic              fb_wbank;
  logic              disp_bank;
  logic              flip;
  logic              ovf;

  modport master (
    output in_data, in_valid, in_sot, in_eot,
    input  fb_waddr, fb_wdata, fb_we, fb_wbank, disp_bank, flip, ovf
  );

  modport slave (
    input  in_data, in_valid, in_sot, in_eot,
    output fb_waddr, fb_wdata, fb_we, fb_wbank, disp_bank, flip, ovf
  );
endinterface
`default_nettype wire

// File: rtl/spi_frame_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : spi_frame_writer
// Brief    : Packs SPI bytes into 24-bit RGB pixels, writes them to the back bank
//            of a double-buffered framebuffer and flips banks at end of transfer.
//            Define SPI_FRAME_WRITER_FRAME_CHECK_EN to flip only on complete frames.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module spi_frame_writer #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 9
) (
  input wire                clk,
  input wire                rst,
  spi_frame_writer_if.slave bus
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
  ,
  output logic              bad_frame
`endif
);

  localparam logic [1:0]      c_IDLE    = 2'd0;
  localparam logic [1:0]      c_RECV    = 2'd1;
  localparam logic [1:0]      c_FLIP    = 2'd2;
  localparam logic [ADDR_W:0] c_TOTAL   = (ADDR_W+1)'(WIDTH * HEIGHT);
  localparam logic [ADDR_W:0] c_CNT_ONE = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_pix_cnt;
  logic [7:0]        r_red;
  logic [7:0]        r_green;
  logic [ADDR_W-1:0] r_waddr;
  logic [23:0]       r_wdata;
  logic              r_we;
  logic              r_disp_bank;
  logic              r_flip;
  logic              r_ovf;
  logic              w_start;
  logic              w_do_flip;

  // A start byte restarts the frame from IDLE or RECV, except when eot wins.
  assign w_start = bus.in_valid && bus.in_sot &&
                   ((r_state == c_IDLE) || ((r_state == c_RECV) && !bus.in_eot));

`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
  logic r_bad_frame;
  assign w_do_flip = (r_pix_cnt == c_TOTAL) && (r_byte_idx == 2'd0) && !r_ovf;
  assign bad_frame = r_bad_frame;
`else
  assign w_do_flip = (r_pix_cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_byte_idx  <= 2'd0;
      r_pix_cnt   <= '0;
      r_red       <= 8'd0;
      r_green     <= 8'd0;
      r_waddr     <= '0;
      r_wdata     <= 24'd0;
      r_we        <= 1'b0;
      r_disp_bank <= 1'b0;
      r_flip      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_flip <= 1'b0;
      if (w_start) begin
        r_state    <= c_RECV;
        r_red      <= bus.in_data;
        r_byte_idx <= 2'd1;
        r_pix_cnt  <= '0;
        r_ovf      <= 1'b0;
      end else begin
        case (r_state)
          c_RECV: begin
            if (bus.in_eot) begin
              r_byte_idx <= 2'd0;
              if (w_do_flip) begin
                r_state     <= c_FLIP;
                r_flip      <= 1'b1;
                r_disp_bank <= ~r_disp_bank;
              end else begin
                r_state <= c_IDLE;
              end
            end else if (bus.in_valid) begin
              case (r_byte_idx)
                2'd0: begin
                  r_red      <= bus.in_data;
                  r_byte_idx <= 2'd1;
                end
                2'd1: begin
                  r_green    <= bus.in_data;
                  r_byte_idx <= 2'd2;
                end
                default: begin
                  r_byte_idx <= 2'd0;
                  // Counter saturates at a full frame; extra pixels only flag overflow.
                  if (r_pix_cnt == c_TOTAL) begin
                    r_ovf <= 1'b1;
                  end else begin
                    r_we      <= 1'b1;
                    r_waddr   <= r_pix_cnt[ADDR_W-1:0];
                    r_wdata   <= {r_red, r_green, bus.in_data};
                    r_pix_cnt <= r_pix_cnt + c_CNT_ONE;
                  end
                end
              endcase
            end
          end
          c_FLIP:  r_state <= c_IDLE;
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bad_frame <= 1'b0;
    end else if ((r_state == c_RECV) && bus.in_eot) begin
      r_bad_frame <= !w_do_flip;
    end
  end
`endif

  assign bus.fb_waddr  = r_waddr;
  assign bus.fb_wdata  = r_wdata;
  assign bus.fb_we     = r_we;
  assign bus.fb_wbank  = ~r_disp_bank;
  assign bus.disp_bank = r_disp_bank;
  assign bus.flip      = r_flip;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_writer.sv
`default_nettype none
// Testbench for spi_frame_writer: directed and random transfers checked against
// a frame-level model built from the byte list of each transfer.
module tb_spi_frame_writer;
  localparam int WIDTH  = 32;
  localparam int HEIGHT = 16;
  localparam int ADDR_W = 9;
  localparam int TOTAL  = WIDTH * HEIGHT;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
    logic              bank;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  spi_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
  logic bad_frame;
`endif

  spi_frame_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    ,
    .bad_frame (bad_frame)
`endif
  );

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         flip_cnt  = 0;
  int         rule_viol = 0;
  logic       exp_disp  = 1'b0;
  logic       exp_flip;
  logic       exp_ovf;

  // Write/flip monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) got_q.push_back({bus.fb_waddr, bus.fb_wdata, bus.fb_wbank});
    if (bus.flip === 1'b1) flip_cnt++;
    if ((bus.fb_we === 1'b1 && bus.flip === 1'b1) || (bus.fb_wbank !== ~bus.disp_bank)) rule_viol++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sot);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.in_sot   = sot;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sot   = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_frame(input int max_gap);
    bus.in_eot = 1'b0;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], i == 0);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
    bus.in_eot = 1'b1;
    idle(4);
  endtask

  // Expected result of tx_q: one write per complete pixel up to a full frame.
  task automatic build_expect();
    int npix;
    int extra;
    npix  = tx_q.size() / 3;
    extra = tx_q.size() % 3;
    exp_q.delete();
    for (int p = 0; p < npix && p < TOTAL; p++)
      exp_q.push_back({ADDR_W'(p), tx_q[3*p], tx_q[3*p+1], tx_q[3*p+2], ~exp_disp});
    exp_ovf = (npix > TOTAL);
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    exp_flip = (npix == TOTAL) && (extra == 0);
`else
    exp_flip = (npix > 0) && (extra >= 0);
`endif
  endtask

  function automatic int count_write_errors();
    int n;
    n = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) n++;
    if (got_q.size() > exp_q.size()) n += got_q.size() - exp_q.size();
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", bus.fb_we); end
    checks++; if (bus.fb_waddr !== '0) begin errors++; $display("FAIL reset_fb_waddr: got %0d want 0", bus.fb_waddr); end
    checks++; if (bus.fb_wdata !== 24'd0) begin errors++; $display("FAIL reset_fb_wdata: got %h want 0", bus.fb_wdata); end
    checks++; if (bus.disp_bank !== 1'b0) begin errors++; $display("FAIL reset_disp_bank: got %b want 0", bus.disp_bank); end
    checks++; if (bus.fb_wbank !== 1'b1) begin errors++; $display("FAIL reset_fb_wbank: got %b want 1", bus.fb_wbank); end
    checks++; if (bus.flip !== 1'b0) begin errors++; $display("FAIL reset_flip: got %b want 0", bus.flip); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    checks++; if (bad_frame !== 1'b0) begin errors++; $display("FAIL reset_bad_frame: got %b want 0", bad_frame); end
`endif
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_full_frame();
    int f0;
    int n;
    tx_q.delete();
    for (int i = 0; i < TOTAL; i++) repeat (3) tx_q.push_back(8'(i));
    build_expect();
    got_q.delete();
    f0 = flip_cnt;
    send_frame(0);
    n = count_write_errors();
    checks++; if (got_q.size() != TOTAL) begin errors++; $display("FAIL full_write_count: got %0d want %0d", got_q.size(), TOTAL); end
    checks++; if (n != 0) begin errors++; $display("FAIL full_write_data: got %0d bad writes want 0", n); end
    checks++;
    if (got_q.size() <= 5 || got_q[5].data !== 24'h050505 || got_q[5].bank !== 1'b1) begin
      errors++; $display("FAIL full_pixel5: got %0d writes, want pixel 5 = 050505 in bank 1", got_q.size());
    end
    checks++; if (flip_cnt - f0 != 1) begin errors++; $display("FAIL full_flip: got %0d flips want 1", flip_cnt - f0); end
    checks++; if (bus.disp_bank !== 1'b1 || bus.fb_wbank !== 1'b0) begin
      errors++; $display("FAIL full_banks: got disp=%b wbank=%b want disp=1 wbank=0", bus.disp_bank, bus.fb_wbank);
    end
    exp_disp = exp_disp ^ exp_flip;
  endtask

  task automatic test_partial_pixel();
    int f0;
    int n;
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_expect();
    got_q.delete();
    f0 = flip_cnt;
    send_frame(1);
    n = count_write_errors();
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== '0 || got_q[0].data !== 24'h112233) begin
      errors++; $display("FAIL partial_write: got %0d writes (bad=%0d) want one write of 112233 at 0", got_q.size(), n);
    end
    checks++; if (flip_cnt - f0 != int'(exp_flip)) begin errors++; $display("FAIL partial_flip: got %0d flips want %0d", flip_cnt - f0, exp_flip); end
    checks++; if (bus.disp_bank !== (exp_disp ^ exp_flip)) begin errors++; $display("FAIL partial_disp: got %b want %b", bus.disp_bank, exp_disp ^ exp_flip); end
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    checks++; if (bad_frame !== ~exp_flip) begin errors++; $display("FAIL partial_bad_frame: got %b want %b", bad_frame, ~exp_flip); end
`endif
    exp_disp = exp_disp ^ exp_flip;
  endtask

  task automatic test_overflow();
    int f0;
    int n;
    tx_q.delete();
    for (int i = 0; i < (TOTAL + 1) * 3; i++) tx_q.push_back(8'($urandom));
    build_expect();
    got_q.delete();
    f0 = flip_cnt;
    bus.in_eot = 1'b0;
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], i == 0);
      if (i == TOTAL * 3 - 1) begin
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.ovf); end
      end
    end
    checks++; if (bus.ovf !== exp_ovf) begin errors++; $display("FAIL ovf_set: got %b want %b", bus.ovf, exp_ovf); end
    bus.in_eot = 1'b1;
    idle(4);
    n = count_write_errors();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++; if (n != 0) begin errors++; $display("FAIL ovf_write_data: got %0d bad writes want 0", n); end
    checks++; if (flip_cnt - f0 != int'(exp_flip)) begin errors++; $display("FAIL ovf_flip: got %0d flips want %0d", flip_cnt - f0, exp_flip); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
    exp_disp = exp_disp ^ exp_flip;
    // The next accepted start byte clears the sticky flag.
    tx_q = '{8'($urandom)};
    build_expect();
    f0 = flip_cnt;
    bus.in_eot = 1'b0;
    send_byte(tx_q[0], 1'b1);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.ovf); end
    bus.in_eot = 1'b1;
    idle(4);
    checks++; if (flip_cnt - f0 != int'(exp_flip)) begin errors++; $display("FAIL ovf_next_flip: got %0d flips want %0d", flip_cnt - f0, exp_flip); end
  endtask

  task automatic test_empty();
    int   f0;
    logic d0;
    tx_q = '{8'($urandom)};
    build_expect();
    got_q.delete();
    f0 = flip_cnt;
    d0 = exp_disp;
    send_frame(0);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", got_q.size()); end
    checks++; if (flip_cnt != f0) begin errors++; $display("FAIL empty_flip: got %0d flips want 0", flip_cnt - f0); end
    checks++; if (bus.disp_bank !== d0) begin errors++; $display("FAIL empty_disp: got %b want %b", bus.disp_bank, d0); end
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    checks++; if (bad_frame !== 1'b1) begin errors++; $display("FAIL empty_bad_frame: got %b want 1", bad_frame); end
`endif
  endtask

  task automatic test_async_reset();
    int f0;
    int n;
    bus.in_eot = 1'b0;
    for (int i = 0; i < 11; i++) send_byte(8'($urandom), i == 0);
    idle(1);
    got_q.delete();
    f0 = flip_cnt;
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.fb_we !== 1'b0 || bus.flip !== 1'b0) begin errors++; $display("FAIL arst_strobes: got we=%b flip=%b want 0 0", bus.fb_we, bus.flip); end
    checks++; if (bus.fb_waddr !== '0 || bus.fb_wdata !== 24'd0) begin errors++; $display("FAIL arst_bus: got addr=%0d data=%h want 0 0", bus.fb_waddr, bus.fb_wdata); end
    checks++; if (bus.disp_bank !== 1'b0 || bus.fb_wbank !== 1'b1) begin errors++; $display("FAIL arst_banks: got disp=%b wbank=%b want 0 1", bus.disp_bank, bus.fb_wbank); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL arst_ovf: got %b want 0", bus.ovf); end
    send_byte(8'($urandom), 1'b0);
    bus.in_eot = 1'b1;
    idle(3);
    checks++; if (got_q.size() != 0 || flip_cnt != f0) begin errors++; $display("FAIL arst_quiet: got %0d writes %0d flips want 0 0", got_q.size(), flip_cnt - f0); end
    rst = 1'b1;
    exp_disp = 1'b0;
    idle(2);
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
    build_expect();
    got_q.delete();
    f0 = flip_cnt;
    send_frame(1);
    n = count_write_errors();
    checks++; if (got_q.size() == 0 || got_q[0].addr !== '0) begin errors++; $display("FAIL arst_restart_addr: got %0d writes, want first at addr 0", got_q.size()); end
    checks++; if (n != 0) begin errors++; $display("FAIL arst_restart_data: got %0d bad writes want 0", n); end
    checks++; if (flip_cnt - f0 != int'(exp_flip)) begin errors++; $display("FAIL arst_restart_flip: got %0d flips want %0d", flip_cnt - f0, exp_flip); end
    exp_disp = exp_disp ^ exp_flip;
  endtask

  task automatic test_random();
    int f0;
    int n;
    int npix;
    for (int t = 0; t < 6; t++) begin
      npix = $urandom_range(40, 1);
      tx_q.delete();
      for (int i = 0; i < npix * 3 + $urandom_range(2, 0); i++) tx_q.push_back(8'($urandom));
      build_expect();
      got_q.delete();
      f0 = flip_cnt;
      send_frame(2);
      n = count_write_errors();
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_write_count: got %0d want %0d", t, got_q.size(), exp_q.size()); end
      checks++; if (n != 0) begin errors++; $display("FAIL rand%0d_write_data: got %0d bad writes want 0", t, n); end
      checks++; if (flip_cnt - f0 != int'(exp_flip)) begin errors++; $display("FAIL rand%0d_flip: got %0d flips want %0d", t, flip_cnt - f0, exp_flip); end
      checks++; if (bus.disp_bank !== (exp_disp ^ exp_flip)) begin errors++; $display("FAIL rand%0d_disp: got %b want %b", t, bus.disp_bank, exp_disp ^ exp_flip); end
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
      checks++; if (bad_frame !== ~exp_flip) begin errors++; $display("FAIL rand%0d_bad_frame: got %b want %b", t, bad_frame, ~exp_flip); end
`endif
      exp_disp = exp_disp ^ exp_flip;
    end
  endtask

`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
  task automatic test_frame_check();
    int f0;
    tx_q.delete();
    for (int i = 0; i < 30; i++) tx_q.push_back(8'($urandom));
    build_expect();
    f0 = flip_cnt;
    send_frame(0);
    checks++; if (flip_cnt != f0) begin errors++; $display("FAIL fc_short_flip: got %0d flips want 0", flip_cnt - f0); end
    checks++; if (bad_frame !== 1'b1) begin errors++; $display("FAIL fc_short_bad: got %b want 1", bad_frame); end
    tx_q.delete();
    for (int i = 0; i < TOTAL * 3; i++) tx_q.push_back(8'($urandom));
    build_expect();
    f0 = flip_cnt;
    send_frame(0);
    checks++; if (flip_cnt - f0 != 1) begin errors++; $display("FAIL fc_full_flip: got %0d flips want 1", flip_cnt - f0); end
    checks++; if (bad_frame !== 1'b0) begin errors++; $display("FAIL fc_full_bad: got %b want 0", bad_frame); end
    exp_disp = exp_disp ^ exp_flip;
  endtask
`endif

  initial begin
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_sot   = 1'b0;
    bus.in_eot   = 1'b1;
    test_reset();
    test_full_frame();
    test_partial_pixel();
    test_overflow();
    test_empty();
    test_async_reset();
    test_random();
`ifdef SPI_FRAME_WRITER_FRAME_CHECK_EN
    test_frame_check();
`endif
    checks++;
    if (rule_viol != 0) begin errors++; $display("FAIL bus_rules: got %0d cycles with we&flip or wbank==disp_bank, want 0", rule_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
